frame_chk: RTL and testbench

Downstream checker for the byte stream leaving the loopback stage (`txd`/`tx_en`). It delimits frames on the valid strobe, strips the 0x55 preamble and 0xD5 SFD, and verifies a trailing one-byte XOR checksum. It keeps saturating per-outcome counters that can be read and cleared over the same 16-bit command bus used elsewhere in the design. Read-only to the stream: it never back-pressures.

---
 rtl/frame_chk.sv | 207 ++++++++++++++++++++
 tb/tb_frame_chk.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_chk.sv
// rtl/frame_chk.sv - frame delimiter, preamble/SFD stripper and XOR checksum checker with counters
//
// Ports:
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   rxd, rx_dv        : incoming stream byte and its valid strobe
//   bus_cmd_valid     : single-cycle command strobe
//   bus_op            : 1 = write, 0 = read
//   bus_addr          : register address, [2:0] decoded, [15:3] must be zero
//   bus_wr_data       : write data (bit0 of a ctrl write clears counters)
//   bus_rd_data       : registered read data, 0 when no read is returning
//   frame_done        : one-cycle pulse at every frame termination
//   frame_ok          : one-cycle pulse with frame_done for good frames only
module frame_chk #(
    parameter int unsigned MAX_LEN = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxd,
    input  logic        rx_dv,
    input  logic        bus_cmd_valid,
    input  logic        bus_op,
    input  logic [15:0] bus_addr,
    input  logic [15:0] bus_wr_data,
    output logic [15:0] bus_rd_data,
    output logic        frame_done,
    output logic        frame_ok
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_DROP = 2'd3
    } state_t;

    // Length needs one bit beyond 16 so that MAX_LEN=65535 plus one byte is representable.
    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

    state_t      state_q, state_d;
    logic [16:0] len_q, len_d;
    logic [7:0]  xor_q, xor_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic [15:0] good_q, good_d;
    logic [15:0] err_pre_q, err_pre_d;
    logic [15:0] err_short_q, err_short_d;
    logic [15:0] err_crc_q, err_crc_d;
    logic [15:0] err_long_q, err_long_d;
    logic [15:0] last_len_q, last_len_d;
    logic [15:0] rd_data_q, rd_data_d;

    logic        inc_good, inc_pre, inc_short, inc_crc, inc_long;
    logic [16:0] len_inc;
    logic        addr_ok, rd_en, clr;
    logic        unused_wr_bits;

    assign unused_wr_bits = ^bus_wr_data[15:1];

    assign len_inc = len_q + 17'd1;
    assign addr_ok = (bus_addr[15:3] == 13'd0);
    assign rd_en   = bus_cmd_valid && !bus_op && addr_ok;
    assign clr     = bus_cmd_valid && bus_op && addr_ok &&
                     (bus_addr[2:0] == 3'd0) && bus_wr_data[0];

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    // Frame FSM and classification
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        xor_d      = xor_q;
        done_d     = 1'b0;
        ok_d       = 1'b0;
        last_len_d = last_len_q;
        inc_good   = 1'b0;
        inc_pre    = 1'b0;
        inc_short  = 1'b0;
        inc_crc    = 1'b0;
        inc_long   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_dv) begin
                    if (rxd == 8'h55) begin
                        state_d = S_PRE;
                    end else begin
                        state_d = S_DROP;
                        inc_pre = 1'b1;
                    end
                end
            end
            S_PRE: begin
                if (!rx_dv) begin
                    state_d = S_IDLE;
                    inc_pre = 1'b1;
                    done_d  = 1'b1;
                end else if (rxd == 8'hD5) begin
                    state_d = S_DATA;
                    len_d   = 17'd0;
                    xor_d   = 8'h00;
                end else if (rxd != 8'h55) begin
                    state_d = S_DROP;
                    inc_pre = 1'b1;
                end
            end
            S_DATA: begin
                if (rx_dv) begin
                    if (len_inc > MAX_LEN_W) begin
                        state_d  = S_DROP;
                        inc_long = 1'b1;
                    end else begin
                        len_d = len_inc;
                        xor_d = xor_q ^ rxd;
                    end
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (len_q < 17'd2) begin
                        inc_short = 1'b1;
                    end else if (xor_q != 8'h00) begin
                        inc_crc = 1'b1;
                    end else begin
                        inc_good   = 1'b1;
                        ok_d       = 1'b1;
                        last_len_d = len_q[15:0];
                    end
                end
            end
            S_DROP: begin
                if (!rx_dv) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        good_d      = sat_inc(good_q, inc_good);
        err_pre_d   = sat_inc(err_pre_q, inc_pre);
        err_short_d = sat_inc(err_short_q, inc_short);
        err_crc_d   = sat_inc(err_crc_q, inc_crc);
        err_long_d  = sat_inc(err_long_q, inc_long);

        // A clear coinciding with a frame end overrides the update.
        if (clr) begin
            good_d      = 16'd0;
            err_pre_d   = 16'd0;
            err_short_d = 16'd0;
            err_crc_d   = 16'd0;
            err_long_d  = 16'd0;
            last_len_d  = 16'd0;
        end
    end

    // Read mux samples the current registers, so a read racing an update sees the old value.
    always_comb begin
        rd_data_d = 16'd0;
        if (rd_en) begin
            case (bus_addr[2:0])
                3'd1:    rd_data_d = good_q;
                3'd2:    rd_data_d = err_pre_q;
                3'd3:    rd_data_d = err_crc_q;
                3'd4:    rd_data_d = err_short_q;
                3'd5:    rd_data_d = err_long_q;
                3'd6:    rd_data_d = last_len_q;
                3'd7:    rd_data_d = {13'd0, state_q, (state_q != S_IDLE)};
                default: rd_data_d = 16'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= 17'd0;
            xor_q       <= 8'h00;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            good_q      <= 16'd0;
            err_pre_q   <= 16'd0;
            err_short_q <= 16'd0;
            err_crc_q   <= 16'd0;
            err_long_q  <= 16'd0;
            last_len_q  <= 16'd0;
            rd_data_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            xor_q       <= xor_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            good_q      <= good_d;
            err_pre_q   <= err_pre_d;
            err_short_q <= err_short_d;
            err_crc_q   <= err_crc_d;
            err_long_q  <= err_long_d;
            last_len_q  <= last_len_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign bus_rd_data = rd_data_q;
    assign frame_done  = done_q;
    assign frame_ok    = ok_q;

endmodule

// File: tb/tb_frame_chk.sv
// tb/tb_frame_chk.sv - scoreboard testbench for frame_chk
module tb_frame_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rxd = 8'h00;
    logic        rx_dv = 1'b0;
    logic        bus_cmd_valid = 1'b0;
    logic        bus_op = 1'b0;
    logic [15:0] bus_addr = 16'd0;
    logic [15:0] bus_wr_data = 16'd0;
    logic [15:0] bus_rd_data;
    logic        frame_done;
    logic        frame_ok;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_rd[$];
    bit          exp_ok[$];
    logic        rd_prev = 1'b0;

    frame_chk #(.MAX_LEN(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd),
        .rx_dv        (rx_dv),
        .bus_cmd_valid(bus_cmd_valid),
        .bus_op       (bus_op),
        .bus_addr     (bus_addr),
        .bus_wr_data  (bus_wr_data),
        .bus_rd_data  (bus_rd_data),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: reads return one cycle after the strobe, pulses are matched against the queue.
    always @(posedge clk) rd_prev <= bus_cmd_valid && !bus_op;

    always @(negedge clk) begin
        if (rd_prev) begin
            if (exp_rd.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rd_unexpected: got %h expected none", bus_rd_data);
            end else begin
                chk("rd_data", bus_rd_data, exp_rd.pop_front());
            end
        end else begin
            chk("rd_idle_zero", bus_rd_data, 16'd0);
        end
        if (frame_done) begin
            if (exp_ok.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL done_unexpected: got 1 expected 0 at %0t", $time);
            end else begin
                chk("frame_ok", {15'd0, frame_ok}, {15'd0, exp_ok.pop_front()});
            end
        end else if (frame_ok) begin
            n_vec++; n_err++;
            $display("FAIL ok_without_done: got 1 expected 0 at %0t", $time);
        end
    end

    task automatic step(input logic dv, input logic [7:0] d);
        @(posedge clk); #1;
        rx_dv = dv; rxd = d; bus_cmd_valid = 1'b0; bus_op = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic end_frame(input bit ok);
        step(1'b0, 8'h00);
        exp_ok.push_back(ok);
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e);
        @(posedge clk); #1;
        bus_cmd_valid = 1'b1; bus_op = 1'b0; bus_addr = a;
        exp_rd.push_back(e);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        bus_cmd_valid = 1'b1; bus_op = 1'b1; bus_addr = a; bus_wr_data = d;
    endtask

    task automatic clear_all();
        wr(16'd0, 16'h0001);
        idle(1);
    endtask

    // Preamble, SFD, payload 12 34 and checksum byte, without the termination cycle.
    task automatic frame_body(input logic [7:0] ck);
        for (int i = 0; i < 7; i++) step(1'b1, 8'h55);
        step(1'b1, 8'hD5);
        step(1'b1, 8'h12);
        step(1'b1, 8'h34);
        step(1'b1, ck);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state of every register
        for (int a = 0; a < 8; a++) rd(16'(a), 16'd0);
        idle(1);

        // Good frame, with a status read while in the preamble (PRE, in frame -> 3)
        step(1'b1, 8'h55);
        rd(16'd7, 16'h0003);
        frame_body(8'h26);
        end_frame(1'b1);
        rd(16'd1, 16'd1);
        rd(16'd6, 16'd3);
        idle(2);

        // Checksum error
        clear_all();
        frame_body(8'h27);
        end_frame(1'b0);
        rd(16'd3, 16'd1);
        rd(16'd1, 16'd0);
        idle(2);

        // Short frames
        clear_all();
        step(1'b1, 8'h55); step(1'b1, 8'hD5); step(1'b1, 8'hA5);
        end_frame(1'b0);
        rd(16'd4, 16'd1);
        step(1'b1, 8'h55); step(1'b1, 8'hD5);
        end_frame(1'b0);
        rd(16'd4, 16'd2);
        idle(2);

        // Bad preamble, status read in DROP (7), then one gap cycle and a good frame
        clear_all();
        step(1'b1, 8'h00);
        rd(16'd7, 16'h0007);
        step(1'b1, 8'h55); step(1'b1, 8'hD5); step(1'b1, 8'h00);
        end_frame(1'b0);
        frame_body(8'h26);
        end_frame(1'b1);
        rd(16'd2, 16'd1);
        rd(16'd1, 16'd1);
        // Preamble cut short by rx_dv low
        step(1'b1, 8'h55); step(1'b1, 8'h55);
        end_frame(1'b0);
        rd(16'd2, 16'd2);
        // Ignored writes and out-of-range addresses
        wr(16'h0008, 16'h0001);
        wr(16'h0001, 16'hFFFF);
        wr(16'h0000, 16'h0000);
        rd(16'd1, 16'd1);
        rd(16'd2, 16'd2);
        rd(16'h0009, 16'd0);
        rd(16'd0, 16'd0);
        rd(16'd6, 16'd3);
        idle(2);

        // Overlength (65 bytes) and exact maximum (64 zero bytes)
        clear_all();
        step(1'b1, 8'h55); step(1'b1, 8'hD5);
        for (int i = 0; i < 65; i++) step(1'b1, 8'h00);
        end_frame(1'b0);
        rd(16'd5, 16'd1);
        rd(16'd1, 16'd0);
        step(1'b1, 8'h55); step(1'b1, 8'hD5);
        for (int i = 0; i < 64; i++) step(1'b1, 8'h00);
        end_frame(1'b0 | 1'b1);
        rd(16'd1, 16'd1);
        rd(16'd6, 16'd64);
        rd(16'd5, 16'd1);
        idle(2);

        // Read coinciding with update returns old value; clear coinciding with update wins
        clear_all();
        frame_body(8'h26);
        @(posedge clk); #1;
        rx_dv = 1'b0; bus_cmd_valid = 1'b1; bus_op = 1'b0; bus_addr = 16'd1;
        exp_rd.push_back(16'd0);
        exp_ok.push_back(1'b1);
        rd(16'd1, 16'd1);
        idle(1);
        frame_body(8'h26);
        @(posedge clk); #1;
        rx_dv = 1'b0; bus_cmd_valid = 1'b1; bus_op = 1'b1; bus_addr = 16'd0; bus_wr_data = 16'h0001;
        exp_ok.push_back(1'b1);
        rd(16'd1, 16'd0);
        rd(16'd6, 16'd0);
        idle(2);

        // Saturation of good
        force dut.good_q = 16'hFFFF;
        idle(2);
        release dut.good_q;
        frame_body(8'h26);
        end_frame(1'b1);
        rd(16'd1, 16'hFFFF);
        idle(2);

        // Reset mid-frame, rx_dv still high afterwards -> DROP and err_pre
        step(1'b1, 8'h55); step(1'b1, 8'hD5); step(1'b1, 8'h12);
        @(posedge clk); #1;
        rst = 1'b1; rx_dv = 1'b1; rxd = 8'h34;
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b1, 8'h26);
        end_frame(1'b0);
        rd(16'd2, 16'd1);
        rd(16'd1, 16'd0);
        rd(16'd7, 16'd0);
        idle(4);

        chk("rd_queue_drained", 16'(exp_rd.size()), 16'd0);
        chk("pulse_queue_drained", 16'(exp_ok.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
